pq_buffer_nb: RTL and testbench

N-bank rotating buffer, the multi-bank successor to the two-bank ping-pong buffer.
- Producer fills banks and consumer drains them in ring order.
- Bank hand-over is by explicit done/ready handshakes, not an external select line.
- An optional built-in sequencer zero-clears each bank on release, so the consumer never needs a clear pass.
- Sits between spike/partial-sum producers and the accumulate stage in the core datapath.

---
 rtl/pq_buffer_pkg.sv | 31 +++
 rtl/dp_ram.sv | 27 ++
 rtl/pq_clear_seq.sv | 66 ++++++
 rtl/pq_buffer_nb.sv | 124 ++++++++++++
 tb/tb_pq_buffer_nb.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pq_buffer_pkg.sv
// Shared types and helpers for the N-bank rotating buffer.
package pq_buffer_pkg;

  localparam int unsigned MIN_BANKS = 2;
  localparam int unsigned MAX_BANKS = 8;
  // Widest bank pointer the helpers need to handle (MAX_BANKS = 8).
  localparam int unsigned PTR_W     = 3;

  typedef enum logic [1:0] {
    FREE,   // writable by the producer
    FULL,   // committed, readable by the consumer
    CLEAR   // released, awaiting or undergoing zeroing
  } bank_state_t;

  typedef enum logic {
    IDLE,
    RUN
  } seq_state_t;

  function automatic bit num_banks_ok(input int unsigned n);
    return (n >= MIN_BANKS) && (n <= MAX_BANKS);
  endfunction

  // Advance a ring pointer, wrapping from n-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input int unsigned       n);
    if ({29'd0, ptr} == n - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
module dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port.
  // NOTE: the storage array is deliberately not reset; resetting a memory
  // forces it into flops and the buffer's contract never relies on it.
  // NOTE: sequential state is always updated with non-blocking assignments
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pq_clear_seq.sv
// Zero-clear sequencer: walks released banks in ring order and writes 0 to
// every address, one per cycle, then hands the bank back as FREE.
module pq_clear_seq
  import pq_buffer_pkg::*;
#(
  parameter  int          ADDR_WIDTH = 4,
  parameter  int unsigned NUM_BANKS  = 3,
  localparam int          BW         = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cur_clear,   // bank at clr_ptr is CLEAR
  input  logic                  next_clear,  // bank after clr_ptr is CLEAR
  input  logic                  at_rd,       // clr_ptr has caught up with rd_ptr
  output logic                  busy,
  output logic [BW-1:0]         clr_ptr,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  done         // last address written this cycle
);

  seq_state_t    state;
  logic          last;
  logic [BW-1:0] ptr_next;

  assign last     = (clr_addr == '1);
  assign done     = busy && last;
  assign ptr_next = BW'(ptr_inc(PTR_W'(clr_ptr), NUM_BANKS));

  // Sequencer FSM: start on a CLEAR bank, chain straight into the next one if
  // it is already pending, and skip banks that were released without a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      clr_ptr  <= '0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          clr_addr <= '0;
          if (cur_clear) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (!at_rd) begin
            clr_ptr <= ptr_next;
          end
        end
        RUN: begin
          clr_addr <= clr_addr + 1'b1;
          if (last) begin
            clr_ptr <= ptr_next;
            if (!next_clear) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pq_buffer_nb.sv
// N-bank rotating buffer: the producer fills banks and the consumer drains
// them in ring order, with done/ready hand-over and optional zero-on-release.
module pq_buffer_nb
  import pq_buffer_pkg::*;
#(
  parameter  int          DATA_WIDTH = 8,
  parameter  int          ADDR_WIDTH = 4,
  parameter  int unsigned NUM_BANKS  = 3,
  localparam int          BW         = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  clr_on_rel,
  output logic                  clr_busy,
  output logic [BW-1:0]         fill_bank,
  output logic [BW-1:0]         drain_bank,
  output logic                  err
);

  if (!num_banks_ok(NUM_BANKS)) begin : g_bad_num_banks
    $error("pq_buffer_nb: NUM_BANKS must be in 2..8");
  end

  bank_state_t           bank_state [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [BW-1:0]         wr_ptr, rd_ptr, clr_ptr, clr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_done;
  logic                  wr_acc, wr_commit, rd_acc, rd_rel, bad_req;

  assign wr_ready   = (bank_state[wr_ptr] == FREE);
  assign rd_ready   = (bank_state[rd_ptr] == FULL);
  assign wr_acc     = wr_en   && wr_ready;
  assign wr_commit  = wr_done && wr_ready;
  assign rd_acc     = rd_en   && rd_ready;
  assign rd_rel     = rd_done && rd_ready;
  assign bad_req    = ((wr_en || wr_done) && !wr_ready) ||
                      ((rd_en || rd_done) && !rd_ready);
  assign fill_bank  = wr_ptr;
  assign drain_bank = rd_ptr;
  assign clr_ptr_nxt = BW'(ptr_inc(PTR_W'(clr_ptr), NUM_BANKS));

  pq_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BANKS  (NUM_BANKS)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .cur_clear  (bank_state[clr_ptr] == CLEAR),
    .next_clear (bank_state[clr_ptr_nxt] == CLEAR),
    .at_rd      (clr_ptr == rd_ptr),
    .busy       (clr_busy),
    .clr_ptr    (clr_ptr),
    .clr_addr   (clr_addr),
    .done       (clr_done)
  );

  // Each bank's write port is shared by the producer and the clear sequencer;
  // they never target the same bank since the fill bank is FREE and the
  // cleared bank is CLEAR. Nothing is written on a reset edge.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic clr_hit, wr_hit;
    assign clr_hit = clr_busy && (clr_ptr == BW'(b));
    assign wr_hit  = wr_acc   && (wr_ptr  == BW'(b));

    dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (!rst && (clr_hit || wr_hit)),
      .waddr (clr_hit ? clr_addr : wr_addr),
      .wdata (clr_hit ? '0 : din),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  // Bank states and ring pointers: commit, release and clear completion always
  // touch three different banks, so all three may land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_state[i] <= FREE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_commit) begin
        bank_state[wr_ptr] <= FULL;
        wr_ptr             <= BW'(ptr_inc(PTR_W'(wr_ptr), NUM_BANKS));
      end
      if (rd_rel) begin
        bank_state[rd_ptr] <= clr_on_rel ? CLEAR : FREE;
        rd_ptr             <= BW'(ptr_inc(PTR_W'(rd_ptr), NUM_BANKS));
      end
      if (clr_done) bank_state[clr_ptr] <= FREE;
    end
  end

  // Registered read data and error pulse; the word is taken from the drain
  // bank at accept, so a same-cycle release cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      err        <= bad_req;
      if (rd_acc) dout <= bank_rdata[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pq_buffer_nb.sv
// Self-checking bench for pq_buffer_nb (3 banks x 16 words x 8 bits).
module tb_pq_buffer_nb;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NB = 3;
  localparam int DEPTH = 16;
  localparam int BW = 2;

  localparam int M_FREE = 0, M_FULL = 1, M_CLEAR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_done, rd_en, rd_done, clr_on_rel;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] din;
  logic          wr_ready, rd_ready, dout_valid, clr_busy, err;
  logic [DW-1:0] dout;
  logic [BW-1:0] fill_bank, drain_bank;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bank contents, bank status, ring positions and a FIFO of
  // banks waiting to be zeroed.
  logic [DW-1:0] m_mem   [NB][DEPTH];
  bit            m_known [NB][DEPTH];
  int            m_state [NB];
  int            m_wr, m_rd;
  int            m_q[$];
  bit            m_busy;
  int            m_pos;
  logic [DW-1:0] exp_dout;
  bit            exp_known, exp_dv, exp_err;

  // Busy-window statistics
  int cyc = 0;
  int busy_cnt, busy_first, busy_last;

  pq_buffer_nb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .din        (din),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_ready   (rd_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clr_on_rel (clr_on_rel),
    .clr_busy   (clr_busy),
    .fill_bank  (fill_bank),
    .drain_bank (drain_bank),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_state[b] = M_FREE;
    m_wr = 0;
    m_rd = 0;
    m_q.delete();
    m_busy = 1'b0;
    m_pos = 0;
    exp_dout = '0;
    exp_known = 1'b1;
    exp_dv = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic clear_stats();
    busy_cnt = 0;
    busy_first = -1;
    busy_last = -1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic cycle();
    bit wrdy, rrdy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wrdy = (m_state[m_wr] == M_FREE);
      rrdy = (m_state[m_rd] == M_FULL);
      exp_err = ((wr_en || wr_done) && !wrdy) || ((rd_en || rd_done) && !rrdy);
      exp_dv = rd_en && rrdy;
      if (exp_dv) begin
        exp_dout  = m_mem[m_rd][rd_addr];
        exp_known = m_known[m_rd][rd_addr];
      end
      // Zeroing engine works on the oldest released bank, one word per clock.
      if (m_busy) begin
        m_mem[m_q[0]][m_pos] = '0;
        m_known[m_q[0]][m_pos] = 1'b1;
        m_pos++;
        if (m_pos == DEPTH) begin
          m_state[m_q[0]] = M_FREE;
          void'(m_q.pop_front());
          m_pos = 0;
          m_busy = (m_q.size() > 0);
        end
      end else if (m_q.size() > 0) begin
        m_busy = 1'b1;
        m_pos = 0;
      end
      if (wr_en && wrdy) begin
        m_mem[m_wr][wr_addr] = din;
        m_known[m_wr][wr_addr] = 1'b1;
      end
      if (wr_done && wrdy) begin
        m_state[m_wr] = M_FULL;
        m_wr = (m_wr + 1) % NB;
      end
      if (rd_done && rrdy) begin
        if (clr_on_rel) begin
          m_state[m_rd] = M_CLEAR;
          m_q.push_back(m_rd);
        end else begin
          m_state[m_rd] = M_FREE;
        end
        m_rd = (m_rd + 1) % NB;
      end
    end
    #1;
    cyc++;
    if (clr_busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    check("wr_ready",   wr_ready,   m_state[m_wr] == M_FREE);
    check("rd_ready",   rd_ready,   m_state[m_rd] == M_FULL);
    check("fill_bank",  fill_bank,  m_wr);
    check("drain_bank", drain_bank, m_rd);
    check("clr_busy",   clr_busy,   m_busy);
    check("err",        err,        exp_err);
    check("dout_valid", dout_valid, exp_dv);
    if (exp_known) check("dout", dout, exp_dout);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_ready"},   wr_ready,   1);
    check({tag, "_rd_ready"},   rd_ready,   0);
    check({tag, "_fill_bank"},  fill_bank,  0);
    check({tag, "_drain_bank"}, drain_bank, 0);
    check({tag, "_clr_busy"},   clr_busy,   0);
    check({tag, "_err"},        err,        0);
    check({tag, "_dout"},       dout,       0);
    check({tag, "_dout_valid"}, dout_valid, 0);
  endtask

  task automatic random_phase(input int n_cycles);
    for (int n = 0; n < n_cycles; n++) begin
      wr_en   = ($urandom_range(0, 9) < 6);
      wr_done = ($urandom_range(0, 9) < 2);
      rd_en   = ($urandom_range(0, 9) < 6);
      rd_done = ($urandom_range(0, 9) < 2);
      wr_addr = AW'($urandom);
      rd_addr = AW'($urandom);
      din     = DW'($urandom);
      cycle();
    end
    idle();
  endtask

  initial begin
    int free_at;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) m_known[b][a] = 1'b0;
    model_reset();
    clear_stats();
    rst = 1'b1; clr_on_rel = 1'b0;
    wr_addr = '0; rd_addr = '0; din = '0;
    idle();

    // Reset state
    cycle();
    cycle();
    check_reset_values("reset");
    rst = 1'b0;

    // Basic fill/drain: 0x10..0x1F into bank 0, commit, read address 5.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); din = DW'(8'h10 + a);
      cycle();
    end
    idle();
    wr_done = 1'b1;
    cycle();
    idle();
    check("basic_fill_bank", fill_bank, 1);
    rd_en = 1'b1; rd_addr = 4'd5;
    cycle();
    idle();
    check("basic_dout", dout, 8'h15);
    check("basic_dout_valid", dout_valid, 1);
    cycle();
    check("basic_valid_drop", dout_valid, 0);

    // Full: commit banks 1 and 2 (write landing in the committing bank), then
    // an illegal write must pulse err and leave bank 0 untouched.
    for (int b = 1; b < NB; b++) begin
      wr_en = 1'b1; wr_done = 1'b1; wr_addr = 4'd0; din = DW'(8'hA0 + b);
      cycle();
    end
    idle();
    check("full_wr_ready", wr_ready, 0);
    wr_en = 1'b1; wr_addr = 4'd5; din = 8'hEE;
    cycle();
    idle();
    check("full_err_pulse", err, 1);
    cycle();
    check("full_err_drop", err, 0);
    rd_en = 1'b1; rd_addr = 4'd5;
    cycle();
    idle();
    check("full_unchanged", dout, 8'h15);

    // Auto-clear of bank 0 on release.
    clr_on_rel = 1'b1;
    clear_stats();
    rd_done = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 30; i++) cycle();
    check("autoclr_busy_cycles", busy_cnt, 16);
    check("autoclr_free", wr_ready, 1);
    wr_en = 1'b1; wr_done = 1'b1; wr_addr = 4'd3; din = 8'h33;
    cycle();
    idle();

    // Back-to-back clears: release banks 1 and 2 on consecutive cycles.
    clear_stats();
    free_at = -1;
    rd_done = 1'b1;
    cycle();
    cycle();
    idle();
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (wr_ready && free_at < 0) free_at = busy_cnt;
    end
    check("b2b_busy_cycles", busy_cnt, 32);
    check("b2b_busy_contig", busy_last - busy_first + 1, 32);
    check("b2b_bank1_first", free_at, 17);
    check("b2b_fill_bank", fill_bank, 1);
    rd_en = 1'b1; rd_addr = 4'd3;
    cycle();
    check("refill_dout", dout, 8'h33);
    rd_addr = 4'd7;
    cycle();
    idle();
    check("cleared_dout", dout, 8'h00);

    // Simultaneous commit, release and read.
    clr_on_rel = 1'b0;
    wr_en = 1'b1; wr_done = 1'b1; wr_addr = 4'd2; din = 8'h5A;
    rd_en = 1'b1; rd_done = 1'b1; rd_addr = 4'd3;
    cycle();
    idle();
    check("simul_dout", dout, 8'h33);
    check("simul_dout_valid", dout_valid, 1);
    check("simul_err", err, 0);
    check("simul_fill_bank", fill_bank, 2);
    check("simul_drain_bank", drain_bank, 1);

    // Reset in the 7th cycle of a clear.
    clr_on_rel = 1'b1;
    clear_stats();
    rd_done = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 20 && busy_cnt < 7; i++) cycle();
    check("midclr_reached", busy_cnt, 7);
    rst = 1'b1;
    cycle();
    check_reset_values("midclr");
    rst = 1'b0;
    cycle();
    check("midclr_stays_idle", clr_busy, 0);

    // Randomised traffic, without and then with zero-on-release.
    clr_on_rel = 1'b0;
    random_phase(400);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clr_on_rel = 1'b1;
    random_phase(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
